// File: rtl/sim_run_controller.sv
// sim_run_controller: harness lifecycle sequencer (reset hold, run, drain, verdict handshake).
// Define SIM_CTRL_HEARTBEAT_EN to add a heartbeat_o pulse every 2^HB_LOG2 run cycles.
module sim_run_controller #(
  parameter int unsigned RESET_CYCLES = 8,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned HB_LOG2      = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [CNT_W-1:0] max_cycles_i,
  input  logic             verbose_i,
  input  logic             success_i,
  input  logic             failure_i,
  output logic             dut_reset_o,
  output logic             printf_cond_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [1:0]       done_status_o,
  output logic [2:0]       state_o
`ifdef SIM_CTRL_HEARTBEAT_EN
  ,
  output logic             heartbeat_o
`endif
);
  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_REPORT = 3'd3,
    S_HALT   = 3'd4
  } state_e;
  localparam logic [1:0] ST_NONE = 2'd0, ST_PASS = 2'd1, ST_FAIL = 2'd2, ST_TIMEOUT = 2'd3;
  state_e           state_q;
  logic [31:0]      hold_q, drain_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       status_q, term_d;
  logic             dut_reset_q, done_valid_q;
  // Terminal priority: failure beats timeout beats success.
  assign term_d = failure_i ? ST_FAIL
                : (max_cycles_i != '0 && cnt_q >= max_cycles_i) ? ST_TIMEOUT
                : success_i ? ST_PASS : ST_NONE;
  assign cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_HOLD;
      hold_q       <= '0;
      drain_q      <= '0;
      cnt_q        <= '0;
      status_q     <= ST_NONE;
      dut_reset_q  <= 1'b1;
      done_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          hold_q <= hold_q + 32'd1;
          if (hold_q == RESET_CYCLES - 1) begin
            state_q     <= S_RUN;
            dut_reset_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (term_d != ST_NONE) begin
            status_q <= term_d;
            drain_q  <= DRAIN_CYCLES;
            if (DRAIN_CYCLES == 0) begin
              state_q      <= S_REPORT;
              done_valid_q <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q - 32'd1;
          if (failure_i && status_q == ST_PASS) status_q <= ST_FAIL;
          if (drain_q == 32'd1) begin
            state_q      <= S_REPORT;
            done_valid_q <= 1'b1;
          end
        end
        S_REPORT: begin
          if (done_ready_i) begin
            state_q      <= S_HALT;
            done_valid_q <= 1'b0;
            dut_reset_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign dut_reset_o   = dut_reset_q;
  assign printf_cond_o = verbose_i && (state_q == S_RUN || state_q == S_DRAIN);
  assign cycle_count_o = cnt_q;
  assign done_valid_o  = done_valid_q;
  assign done_status_o = status_q;
  assign state_o       = state_q;
`ifdef SIM_CTRL_HEARTBEAT_EN
  assign heartbeat_o = state_q == S_RUN && &cnt_q[HB_LOG2-1:0];
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (heartbeat_o && verbose_i) $display("heartbeat cycle_count=%0d", cnt_q);
  end
`endif
`endif
endmodule
